// File: rtl/saat_pkg.sv
// Shared definitions for the clock setting sequencer: field indices, FSM states
// and the field-advance helper.
package saat_pkg;

  localparam int ALAN_W = 3;

  localparam logic [ALAN_W-1:0] ALAN_SANIYE = 3'd0;
  localparam logic [ALAN_W-1:0] ALAN_DAKIKA = 3'd1;
  localparam logic [ALAN_W-1:0] ALAN_SAAT   = 3'd2;
  localparam logic [ALAN_W-1:0] ALAN_GUN    = 3'd3;
  localparam logic [ALAN_W-1:0] ALAN_AY     = 3'd4;
  localparam logic [ALAN_W-1:0] ALAN_YIL    = 3'd5;

  typedef enum logic {
    CALIS = 1'b0,
    AYAR  = 1'b1
  } durum_t;

  // Next field index, wrapping back to seconds after the last field.
  function automatic logic [ALAN_W-1:0] sonraki_alan(input logic [ALAN_W-1:0] alan,
                                                     input logic [ALAN_W-1:0] son);
    logic [ALAN_W-1:0] sonuc;
    if (alan == son) begin
      sonuc = ALAN_SANIYE;
    end else begin
      sonuc = alan + 3'd1;
    end
    return sonuc;
  endfunction

endpackage

// File: rtl/buton_tekrar.sv
// Edge detection, both-pressed lockout and hold-to-repeat timing for the
// increment/decrement button pair. Requests are combinational, one cycle each.
module buton_tekrar
  import saat_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic blk,
  input  logic arttir,
  input  logic azalt,
  output logic inc_req,
  output logic dec_req
);

  localparam int unsigned MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LIM  = CW'(REPEAT_CYC - 1);

  logic          art_prev_r, az_prev_r;
  logic          lock_r, lock_s;
  logic          active_r, active_s;
  logic          dir_r, dir_s;
  logic          rep_r, rep_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [CW-1:0] lim_s;
  logic          art_rise_s, az_rise_s;

  // Request generation and next values of the hold/repeat tracking state.
  always_comb begin
    art_rise_s = arttir & ~art_prev_r;
    az_rise_s  = azalt & ~az_prev_r;
    lim_s      = rep_r ? REP_LIM : HOLD_LIM;
    inc_req    = 1'b0;
    dec_req    = 1'b0;
    lock_s     = lock_r;
    active_s   = active_r;
    dir_s      = dir_r;
    rep_s      = rep_r;
    cnt_s      = cnt_r;
    if (!en) begin
      lock_s   = lock_r & (arttir | azalt);
      active_s = 1'b0;
      rep_s    = 1'b0;
      cnt_s    = {CW{1'b0}};
    end else if (arttir && azalt) begin
      lock_s   = 1'b1;
      active_s = 1'b0;
      rep_s    = 1'b0;
      cnt_s    = {CW{1'b0}};
    end else if (lock_r) begin
      // Lockout only releases once both buttons have been let go.
      lock_s   = arttir | azalt;
      active_s = 1'b0;
      rep_s    = 1'b0;
      cnt_s    = {CW{1'b0}};
    end else if (blk) begin
      lock_s   = art_rise_s | az_rise_s;
      active_s = 1'b0;
      rep_s    = 1'b0;
      cnt_s    = {CW{1'b0}};
    end else if (art_rise_s) begin
      inc_req  = 1'b1;
      active_s = 1'b1;
      dir_s    = 1'b1;
      rep_s    = 1'b0;
      cnt_s    = {CW{1'b0}};
    end else if (az_rise_s) begin
      dec_req  = 1'b1;
      active_s = 1'b1;
      dir_s    = 1'b0;
      rep_s    = 1'b0;
      cnt_s    = {CW{1'b0}};
    end else if (active_r && (dir_r ? arttir : azalt)) begin
      if (cnt_r == lim_s) begin
        inc_req = dir_r;
        dec_req = ~dir_r;
        rep_s   = 1'b1;
        cnt_s   = {CW{1'b0}};
      end else begin
        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      active_s = 1'b0;
      rep_s    = 1'b0;
      cnt_s    = {CW{1'b0}};
    end
  end

  // Button history and hold/repeat state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      art_prev_r <= 1'b0;
      az_prev_r  <= 1'b0;
      lock_r     <= 1'b0;
      active_r   <= 1'b0;
      dir_r      <= 1'b0;
      rep_r      <= 1'b0;
      cnt_r      <= {CW{1'b0}};
    end else begin
      art_prev_r <= arttir;
      az_prev_r  <= azalt;
      lock_r     <= lock_s;
      active_r   <= active_s;
      dir_r      <= dir_s;
      rep_r      <= rep_s;
      cnt_r      <= cnt_s;
    end
  end

endmodule

// File: rtl/ayar_kontrol.sv
// Run/set sequencer for the time-field counters: seconds tick, field selection,
// routed inc/dec pulses with hold-to-repeat, idle timeout and blink enable.
module ayar_kontrol
  import saat_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000,
  parameter int unsigned TIMEOUT_S  = 30,
  parameter int unsigned NUM_FIELDS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mod_buton,
  input  logic                  arttir_buton,
  input  logic                  azalt_buton,
  output logic                  stop,
  output logic                  saniye_tick,
  output logic [ALAN_W-1:0]     alan_sec,
  output logic [NUM_FIELDS-1:0] arttir_pulse,
  output logic [NUM_FIELDS-1:0] azalt_pulse,
  output logic                  yanip_sonme
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRESC_SON = PW'(TICK_DIV - 1);
  localparam longint unsigned TO_CYC = 64'(TIMEOUT_S) * 64'(TICK_DIV);
  localparam int IW = $clog2(TO_CYC + 64'd1);
  localparam logic [IW-1:0] TO_LIM = IW'(TO_CYC - 64'd1);
  localparam int unsigned BLINK_Q = ((TICK_DIV / 4) > 0) ? (TICK_DIV / 4) : 1;
  localparam int BW = $clog2(BLINK_Q + 1);
  localparam logic [BW-1:0] BLINK_SON = BW'(BLINK_Q - 1);
  localparam logic [ALAN_W-1:0] SON_ALAN = ALAN_W'(NUM_FIELDS - 1);

  durum_t                durum_r, durum_s;
  logic                  mod_prev_r;
  logic [ALAN_W-1:0]     alan_r, alan_s;
  logic [PW-1:0]         presc_r, presc_s;
  logic [IW-1:0]         idle_r, idle_s;
  logic [BW-1:0]         blink_cnt_r, blink_cnt_s;
  logic                  blink_r, blink_s;
  logic                  tick_r, tick_s;
  logic                  stop_r, stop_s;
  logic [NUM_FIELDS-1:0] art_pulse_r, art_pulse_s;
  logic [NUM_FIELDS-1:0] az_pulse_r, az_pulse_s;
  logic [NUM_FIELDS-1:0] tek_sicak_s;
  logic                  mod_rise_s, aktif_s, ayarda_s;
  logic                  kal_calis_s, kal_ayar_s;
  logic                  inc_req_s, dec_req_s;

  assign mod_rise_s = mod_buton & ~mod_prev_r;
  assign aktif_s    = mod_buton | arttir_buton | azalt_buton;
  assign ayarda_s   = (durum_r == AYAR);

  buton_tekrar #(
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC)
  ) u_buton_tekrar (
    .clk    (clk),
    .reset  (reset),
    .en     (ayarda_s),
    .blk    (mod_rise_s),
    .arttir (arttir_buton),
    .azalt  (azalt_buton),
    .inc_req(inc_req_s),
    .dec_req(dec_req_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      durum_r <= CALIS;
    end else begin
      durum_r <= durum_s;
    end
  end

  // FSM next-state: mode button entry/exit and idle timeout.
  always_comb begin
    durum_s = durum_r;
    case (durum_r)
      CALIS: begin
        if (mod_rise_s) begin
          durum_s = AYAR;
        end else begin
          durum_s = CALIS;
        end
      end
      AYAR: begin
        if (mod_rise_s && (alan_r == SON_ALAN)) begin
          durum_s = CALIS;
        end else if (!aktif_s && (idle_r == TO_LIM)) begin
          durum_s = CALIS;
        end else begin
          durum_s = AYAR;
        end
      end
      default: durum_s = CALIS;
    endcase
  end

  // FSM outputs: next values of every registered output and counter.
  always_comb begin
    kal_calis_s = (durum_r == CALIS) && (durum_s == CALIS);
    kal_ayar_s  = (durum_r == AYAR) && (durum_s == AYAR);
    tek_sicak_s = {{(NUM_FIELDS-1){1'b0}}, 1'b1} << alan_r;

    if (durum_s != AYAR) begin
      alan_s = ALAN_SANIYE;
    end else if (durum_r != AYAR) begin
      alan_s = ALAN_SANIYE;
    end else if (mod_rise_s) begin
      alan_s = sonraki_alan(alan_r, SON_ALAN);
    end else begin
      alan_s = alan_r;
    end

    // Prescaler restarts from zero whenever run mode is (re)entered.
    if (kal_calis_s) begin
      presc_s = (presc_r == PRESC_SON) ? {PW{1'b0}} : presc_r + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      presc_s = {PW{1'b0}};
    end
    tick_s = kal_calis_s && (presc_r == PRESC_SON);

    if (kal_ayar_s && !aktif_s) begin
      idle_s = idle_r + {{(IW-1){1'b0}}, 1'b1};
    end else begin
      idle_s = {IW{1'b0}};
    end

    if (kal_ayar_s) begin
      if (blink_cnt_r == BLINK_SON) begin
        blink_cnt_s = {BW{1'b0}};
        blink_s     = ~blink_r;
      end else begin
        blink_cnt_s = blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
        blink_s     = blink_r;
      end
    end else begin
      blink_cnt_s = {BW{1'b0}};
      blink_s     = 1'b1;
    end

    stop_s      = (durum_s == AYAR);
    art_pulse_s = inc_req_s ? tek_sicak_s : {NUM_FIELDS{1'b0}};
    az_pulse_s  = dec_req_s ? tek_sicak_s : {NUM_FIELDS{1'b0}};
  end

  // Output and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mod_prev_r  <= 1'b0;
      alan_r      <= ALAN_SANIYE;
      presc_r     <= {PW{1'b0}};
      idle_r      <= {IW{1'b0}};
      blink_cnt_r <= {BW{1'b0}};
      blink_r     <= 1'b1;
      tick_r      <= 1'b0;
      stop_r      <= 1'b0;
      art_pulse_r <= {NUM_FIELDS{1'b0}};
      az_pulse_r  <= {NUM_FIELDS{1'b0}};
    end else begin
      mod_prev_r  <= mod_buton;
      alan_r      <= alan_s;
      presc_r     <= presc_s;
      idle_r      <= idle_s;
      blink_cnt_r <= blink_cnt_s;
      blink_r     <= blink_s;
      tick_r      <= tick_s;
      stop_r      <= stop_s;
      art_pulse_r <= art_pulse_s;
      az_pulse_r  <= az_pulse_s;
    end
  end

  assign stop         = stop_r;
  assign saniye_tick  = tick_r;
  assign alan_sec     = alan_r;
  assign arttir_pulse = art_pulse_r;
  assign azalt_pulse  = az_pulse_r;
  assign yanip_sonme  = blink_r;

endmodule

// File: tb/tb_ayar_kontrol.sv
// Directed and randomized checks of ayar_kontrol with short timing parameters.
module tb_ayar_kontrol;

  localparam int TD = 10;
  localparam int HC = 20;
  localparam int RC = 5;
  localparam int TS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mod_buton = 1'b0;
  logic       arttir_buton = 1'b0;
  logic       azalt_buton = 1'b0;
  logic       stop, saniye_tick, yanip_sonme;
  logic [2:0] alan_sec;
  logic [5:0] arttir_pulse, azalt_pulse;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lastact = 0;

  ayar_kontrol #(
    .TICK_DIV(TD), .HOLD_CYC(HC), .REPEAT_CYC(RC), .TIMEOUT_S(TS), .NUM_FIELDS(6)
  ) dut (
    .clk(clk), .reset(reset), .mod_buton(mod_buton), .arttir_buton(arttir_buton),
    .azalt_buton(azalt_buton), .stop(stop), .saniye_tick(saniye_tick), .alan_sec(alan_sec),
    .arttir_pulse(arttir_pulse), .azalt_pulse(azalt_pulse), .yanip_sonme(yanip_sonme)
  );

  always #5 clk = ~clk;

  task automatic step();
    logic a;
    a = mod_buton | arttir_buton | azalt_buton;
    @(posedge clk);
    cyc++;
    if (a) lastact = cyc;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_mod();
    mod_buton = 1'b1;
    step();
    mod_buton = 1'b0;
    step();
  endtask

  initial begin
    logic [5:0] one6;
    logic [5:0] exp_p;
    int e, e2, toggles, w, k, dir, len;
    logic prevb;
    one6 = 6'd1;

    // Reset values
    #12;
    chk("rst_stop", stop, 0);
    chk("rst_alan", alan_sec, 0);
    chk("rst_tick", saniye_tick, 0);
    chk("rst_art", arttir_pulse, 0);
    chk("rst_az", azalt_pulse, 0);
    chk("rst_blink", yanip_sonme, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;

    // 1: run mode ticks every TD cycles
    for (int n = 1; n <= 35; n++) begin
      step();
      chk("t1_tick", saniye_tick, (n % TD) == 0);
      chk("t1_stop", stop, 0);
    end
    chk("t1_alan", alan_sec, 0);
    chk("t1_blink", yanip_sonme, 1);

    // 2: enter set mode, walk fields, exit and check tick phase
    mod_buton = 1'b1;
    step();
    chk("t2_stop", stop, 1);
    chk("t2_alan0", alan_sec, 0);
    mod_buton = 1'b0;
    step();
    chk("t2_notick", saniye_tick, 0);
    press_mod();
    press_mod();
    chk("t2_alan2", alan_sec, 2);
    for (int i = 0; i < 3; i++) press_mod();
    chk("t2_alan5", alan_sec, 5);
    mod_buton = 1'b1;
    step();
    chk("t2_exit_stop", stop, 0);
    chk("t2_exit_alan", alan_sec, 0);
    e = cyc;
    mod_buton = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      chk("t2_tick", saniye_tick, cyc == e + TD);
    end

    // 3: hold arttir 40 cycles at field 2
    press_mod();
    press_mod();
    press_mod();
    chk("t3_alan", alan_sec, 2);
    arttir_buton = 1'b1;
    for (int j = 0; j < 40; j++) begin
      step();
      exp_p = (j == 0 || j == 20 || j == 25 || j == 30 || j == 35) ? 6'b000100 : 6'b000000;
      chk("t3_art", arttir_pulse, exp_p);
      chk("t3_az", azalt_pulse, 0);
    end
    arttir_buton = 1'b0;
    step();
    chk("t3_rel", arttir_pulse, 0);

    // 4: both-pressed lockout
    arttir_buton = 1'b1;
    step();
    chk("t4_first", arttir_pulse, 6'b000100);
    step();
    step();
    azalt_buton = 1'b1;
    step();
    chk("t4_both_art", arttir_pulse, 0);
    chk("t4_both_az", azalt_pulse, 0);
    azalt_buton = 1'b0;
    for (int n = 0; n < 25; n++) begin
      step();
      chk("t4_lock_art", arttir_pulse, 0);
      chk("t4_lock_az", azalt_pulse, 0);
    end
    arttir_buton = 1'b0;
    step();
    chk("t4_low", arttir_pulse, 0);
    arttir_buton = 1'b1;
    step();
    chk("t4_new", arttir_pulse, 6'b000100);
    arttir_buton = 1'b0;
    step();
    chk("t4_one", arttir_pulse, 0);

    // mod edge and arttir edge together: mod wins, edge dropped
    mod_buton = 1'b1;
    arttir_buton = 1'b1;
    step();
    chk("mw_art", arttir_pulse, 0);
    chk("mw_alan", alan_sec, 3);
    mod_buton = 1'b0;
    arttir_buton = 1'b0;
    step();
    arttir_buton = 1'b1;
    step();
    chk("mw_after", arttir_pulse, 6'b001000);
    arttir_buton = 1'b0;
    step();
    azalt_buton = 1'b1;
    step();
    chk("mw_dec", azalt_pulse, 6'b001000);
    chk("mw_dec_art", arttir_pulse, 0);
    azalt_buton = 1'b0;
    step();

    // 5: idle timeout
    w = 0;
    while (stop === 1'b1 && w < 40) begin
      step();
      w++;
    end
    chk("t5_exit0", cyc, lastact + TS * TD);
    mod_buton = 1'b1;
    step();
    e = cyc;
    mod_buton = 1'b0;
    toggles = 0;
    prevb = yanip_sonme;
    for (int n = 1; n <= 29; n++) begin
      step();
      chk("t5a_stop", stop, 1);
      if (n >= 5 && n <= 24 && yanip_sonme !== prevb) toggles++;
      prevb = yanip_sonme;
    end
    chk("t5a_blink_toggles", toggles, 10);
    step();
    chk("t5a_cyc", cyc, e + 30);
    chk("t5a_exit", stop, 0);
    chk("t5a_blink_run", yanip_sonme, 1);
    mod_buton = 1'b1;
    step();
    e2 = cyc;
    mod_buton = 1'b0;
    for (int n = 1; n <= 24; n++) step();
    arttir_buton = 1'b1;
    step();
    chk("t5b_press", arttir_pulse, 6'b000001);
    arttir_buton = 1'b0;
    for (int n = 26; n <= 55; n++) begin
      step();
      chk("t5b_stop", stop, n < 55);
    end

    // 6: reset while holding arttir at field 4
    press_mod();
    for (int i = 0; i < 4; i++) press_mod();
    chk("t6_alan", alan_sec, 4);
    arttir_buton = 1'b1;
    step();
    chk("t6_pulse", arttir_pulse, 6'b010000);
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_stop", stop, 0);
    chk("t6_alan0", alan_sec, 0);
    chk("t6_art", arttir_pulse, 0);
    chk("t6_az", azalt_pulse, 0);
    chk("t6_tick", saniye_tick, 0);
    chk("t6_blink", yanip_sonme, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      chk("t6_rel_art", arttir_pulse, 0);
      chk("t6_rel_stop", stop, 0);
      chk("t6_rel_tick", saniye_tick, (n % TD) == 0);
    end
    arttir_buton = 1'b0;
    step();

    // Randomized holds against an event-time model
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 4);
      dir = $urandom_range(0, 1);
      len = $urandom_range(1, 45);
      press_mod();
      for (int i = 0; i < k; i++) press_mod();
      chk("rnd_alan", alan_sec, k);
      if (dir == 1) arttir_buton = 1'b1;
      else azalt_buton = 1'b1;
      for (int j = 0; j < len; j++) begin
        step();
        exp_p = 6'b000000;
        if (j == 0 || (j >= HC && ((j - HC) % RC) == 0)) exp_p = one6 << k;
        chk("rnd_art", arttir_pulse, (dir == 1) ? exp_p : 6'b000000);
        chk("rnd_az", azalt_pulse, (dir == 0) ? exp_p : 6'b000000);
        chk("rnd_onehot", $countones(arttir_pulse | azalt_pulse) <= 1, 1);
      end
      arttir_buton = 1'b0;
      azalt_buton = 1'b0;
      step();
      chk("rnd_rel", arttir_pulse | azalt_pulse, 0);
      w = 0;
      while (stop === 1'b1 && w < 40) begin
        step();
        w++;
      end
      chk("rnd_timeout", cyc, lastact + TS * TD);
      chk("rnd_exit_alan", alan_sec, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
